// File: rtl/modbus_req_ctrl_pkg.sv
// Shared Modbus definitions: function/exception codes, controller states and response types.
package modbus_req_ctrl_pkg;

    localparam logic [7:0] FUNC_READ_HOLDING = 8'h03;
    localparam logic [7:0] FUNC_WRITE_SINGLE = 8'h06;

    localparam logic [7:0] EXC_ILLEGAL_FUNC  = 8'h01;
    localparam logic [7:0] EXC_ILLEGAL_ADDR  = 8'h02;
    localparam logic [7:0] EXC_ILLEGAL_VALUE = 8'h03;

    typedef enum logic [2:0] {
        StIdle,
        StCrcWait,
        StCheck,
        StWrite,
        StRead,
        StTx
    } state_e;

    typedef enum logic [1:0] {
        RspWrite,
        RspRead,
        RspExc
    } rsp_e;

    // Response length in bytes, excluding the CRC appended downstream.
    function automatic logic [7:0] rsp_len(rsp_e rsp, logic [7:0] qty);
        logic [7:0] len;
        case (rsp)
            RspWrite: len = 8'd6;
            RspRead:  len = 8'd3 + (qty << 1);
            default:  len = 8'd3;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/modbus_rsp_mux.sv
// Response byte selector: maps the current byte index onto the response frame layout.
module modbus_rsp_mux
    import modbus_req_ctrl_pkg::*;
#(
    parameter logic [7:0]  ADDR    = 8'h01,
    parameter int unsigned MAX_QTY = 8
) (
    input  logic [7:0]               byte_idx,
    input  rsp_e                     rsp_type,
    input  logic [7:0]               func_code,
    input  logic [15:0]              addr,
    input  logic [15:0]              data,
    input  logic [7:0]               exc_code,
    input  logic [MAX_QTY-1:0][15:0] rd_buf,
    output logic [7:0]               tx_byte
);

    logic [7:0]  data_idx;
    logic [15:0] word;

    assign data_idx = byte_idx - 8'd3;

    always_comb begin
        word = 16'h0000;
        for (int i = 0; i < int'(MAX_QTY); i++) begin
            if (data_idx[7:1] == 7'(i)) word = rd_buf[i];
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        if (byte_idx == 8'd0) begin
            tx_byte = ADDR;
        end else if (byte_idx == 8'd1) begin
            tx_byte = (rsp_type == RspExc) ? (func_code | 8'h80) : func_code;
        end else begin
            case (rsp_type)
                RspWrite: begin
                    case (byte_idx)
                        8'd2:    tx_byte = addr[15:8];
                        8'd3:    tx_byte = addr[7:0];
                        8'd4:    tx_byte = data[15:8];
                        8'd5:    tx_byte = data[7:0];
                        default: tx_byte = 8'h00;
                    endcase
                end
                RspRead: begin
                    if (byte_idx == 8'd2) tx_byte = {data[6:0], 1'b0};
                    else                  tx_byte = data_idx[0] ? word[7:0] : word[15:8];
                end
                default: begin
                    if (byte_idx == 8'd2) tx_byte = exc_code;
                end
            endcase
        end
    end

endmodule

// File: rtl/modbus_req_ctrl.sv
// Modbus slave request controller for functions 0x03/0x06: validates, accesses registers,
// and streams the response frame (without CRC) to the frame transmitter.
module modbus_req_ctrl
    import modbus_req_ctrl_pkg::*;
#(
    parameter logic [7:0]  ADDR    = 8'h01,
    parameter int unsigned REG_NUM = 16,
    parameter int unsigned MAX_QTY = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rx_message_done,
    input  logic [7:0]  func_code,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    input  logic        crc_done,
    input  logic        crc_ok,
    output logic        reg_rd_en,
    output logic        reg_wr_en,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_last,
    output logic        busy
);

    state_e                   state_q;
    rsp_e                     rsp_q;
    logic [7:0]               func_q;
    logic [15:0]              addr_q;
    logic [15:0]              data_q;
    logic [7:0]               exc_q;
    logic [7:0]               idx_q;
    logic [7:0]               iss_q;
    logic [7:0]               cap_q;
    logic                     pend_q;
    logic [MAX_QTY-1:0][15:0] rd_buf_q;

    logic        is_rd;
    logic        is_wr;
    logic [16:0] end_addr;
    logic [7:0]  chk_exc;
    logic [7:0]  last_idx;
    logic [7:0]  mux_byte;

    assign is_rd    = (func_q == FUNC_READ_HOLDING);
    assign is_wr    = (func_q == FUNC_WRITE_SINGLE);
    // 17-bit sum so addr+qty near 0xFFFF cannot wrap into range.
    assign end_addr = {1'b0, addr_q} + {1'b0, data_q};
    assign last_idx = rsp_len(rsp_q, data_q[7:0]) - 8'd1;

    always_comb begin
        chk_exc = 8'h00;
        if (!is_rd && !is_wr) begin
            chk_exc = EXC_ILLEGAL_FUNC;
        end else if (is_rd && (data_q == 16'd0 || data_q > 16'(MAX_QTY))) begin
            chk_exc = EXC_ILLEGAL_VALUE;
        end else if ((is_rd && end_addr > 17'(REG_NUM)) ||
                     (is_wr && {1'b0, addr_q} >= 17'(REG_NUM))) begin
            chk_exc = EXC_ILLEGAL_ADDR;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= StIdle;
            rsp_q     <= RspWrite;
            func_q    <= 8'h00;
            addr_q    <= 16'h0000;
            data_q    <= 16'h0000;
            exc_q     <= 8'h00;
            idx_q     <= 8'h00;
            iss_q     <= 8'h00;
            cap_q     <= 8'h00;
            pend_q    <= 1'b0;
            rd_buf_q  <= '0;
            reg_rd_en <= 1'b0;
            reg_wr_en <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 16'h0000;
            tx_valid  <= 1'b0;
        end else begin
            pend_q <= reg_rd_en;
            case (state_q)
                StIdle: begin
                    if (rx_message_done) begin
                        func_q  <= func_code;
                        addr_q  <= addr;
                        data_q  <= data;
                        state_q <= StCrcWait;
                    end
                end
                StCrcWait: begin
                    if (crc_done) state_q <= crc_ok ? StCheck : StIdle;
                end
                StCheck: begin
                    if (chk_exc != 8'h00) begin
                        exc_q    <= chk_exc;
                        rsp_q    <= RspExc;
                        idx_q    <= 8'h00;
                        tx_valid <= 1'b1;
                        state_q  <= StTx;
                    end else if (is_rd) begin
                        rsp_q     <= RspRead;
                        reg_rd_en <= 1'b1;
                        reg_addr  <= addr_q[7:0];
                        iss_q     <= 8'd1;
                        cap_q     <= 8'd0;
                        state_q   <= StRead;
                    end else begin
                        rsp_q     <= RspWrite;
                        reg_wr_en <= 1'b1;
                        reg_addr  <= addr_q[7:0];
                        reg_wdata <= data_q;
                        state_q   <= StWrite;
                    end
                end
                StWrite: begin
                    reg_wr_en <= 1'b0;
                    idx_q     <= 8'h00;
                    tx_valid  <= 1'b1;
                    state_q   <= StTx;
                end
                StRead: begin
                    if (iss_q < data_q[7:0]) begin
                        reg_rd_en <= 1'b1;
                        reg_addr  <= addr_q[7:0] + iss_q;
                        iss_q     <= iss_q + 8'd1;
                    end else begin
                        reg_rd_en <= 1'b0;
                    end
                    // reg_rdata belongs to the strobe issued one cycle earlier.
                    if (pend_q) begin
                        for (int i = 0; i < int'(MAX_QTY); i++) begin
                            if (cap_q == 8'(i)) rd_buf_q[i] <= reg_rdata;
                        end
                        cap_q <= cap_q + 8'd1;
                        if (cap_q == data_q[7:0] - 8'd1) begin
                            idx_q    <= 8'h00;
                            tx_valid <= 1'b1;
                            state_q  <= StTx;
                        end
                    end
                end
                StTx: begin
                    if (tx_ready) begin
                        if (idx_q == last_idx) begin
                            tx_valid <= 1'b0;
                            idx_q    <= 8'h00;
                            state_q  <= StIdle;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    modbus_rsp_mux #(
        .ADDR    (ADDR),
        .MAX_QTY (MAX_QTY)
    ) u_rsp_mux (
        .byte_idx  (idx_q),
        .rsp_type  (rsp_q),
        .func_code (func_q),
        .addr      (addr_q),
        .data      (data_q),
        .exc_code  (exc_q),
        .rd_buf    (rd_buf_q),
        .tx_byte   (mux_byte)
    );

    assign tx_byte = tx_valid ? mux_byte : 8'h00;
    assign tx_last = tx_valid && (idx_q == last_idx);
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_modbus_req_ctrl.sv
// Scoreboard bench for modbus_req_ctrl: a reference model queues expected strobes and bytes.
module tb_modbus_req_ctrl;

    logic        clk_in;
    logic        rst_n_in;
    logic        rx_message_done;
    logic [7:0]  func_code;
    logic [15:0] addr;
    logic [15:0] data;
    logic        crc_done;
    logic        crc_ok;
    logic        reg_rd_en;
    logic        reg_wr_en;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic        tx_last;
    logic        busy;

    modbus_req_ctrl u_dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .rx_message_done (rx_message_done),
        .func_code       (func_code),
        .addr            (addr),
        .data            (data),
        .crc_done        (crc_done),
        .crc_ok          (crc_ok),
        .reg_rd_en       (reg_rd_en),
        .reg_wr_en       (reg_wr_en),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_byte         (tx_byte),
        .tx_last         (tx_last),
        .busy            (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int n_bytes = 0;

    logic [8:0]  byte_q[$];
    logic [23:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [15:0] mem [256];
    logic        stall = 1'b0;
    logic        rand_rdy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue the strobes and bytes a correct slave must produce.
    task automatic expect_rsp(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d);
        logic [7:0] b[$];
        logic [7:0] exc;
        logic [15:0] w;
        exc = 8'h00;
        if (f != 8'h03 && f != 8'h06)                 exc = 8'h01;
        else if (f == 8'h03 && (d == 0 || d > 16'd8)) exc = 8'h03;
        else if (f == 8'h03 && int'(a) + int'(d) > 16) exc = 8'h02;
        else if (f == 8'h06 && a >= 16'd16)           exc = 8'h02;
        b.push_back(8'h01);
        if (exc != 8'h00) begin
            b.push_back(f | 8'h80);
            b.push_back(exc);
        end else if (f == 8'h06) begin
            b.push_back(8'h06);
            b.push_back(a[15:8]);
            b.push_back(a[7:0]);
            b.push_back(d[15:8]);
            b.push_back(d[7:0]);
            wr_q.push_back({a[7:0], d});
        end else begin
            b.push_back(8'h03);
            b.push_back({d[6:0], 1'b0});
            for (int i = 0; i < int'(d); i++) begin
                w = mem[int'(a) + i];
                rd_q.push_back(8'(int'(a) + i));
                b.push_back(w[15:8]);
                b.push_back(w[7:0]);
            end
        end
        for (int i = 0; i < b.size(); i++) byte_q.push_back({i == b.size() - 1, b[i]});
    endtask

    // Register file model: read data valid the cycle after the strobe.
    initial begin
        logic        p_rd, p_wr;
        logic [7:0]  p_addr;
        logic [15:0] p_wdata;
        reg_rdata = 16'h0000;
        forever begin
            @(negedge clk_in);
            p_rd = reg_rd_en; p_wr = reg_wr_en; p_addr = reg_addr; p_wdata = reg_wdata;
            @(posedge clk_in);
            #1;
            if (p_rd) reg_rdata = mem[p_addr];
            if (p_wr) mem[p_addr] = p_wdata;
        end
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            tx_ready = stall ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: every strobe and every accepted byte is popped from the scoreboard.
    initial begin
        logic [8:0]  eb;
        logic [23:0] ew;
        forever begin
            @(negedge clk_in);
            if (rst_n_in) begin
                if (reg_rd_en && reg_wr_en) check_eq("rd_wr_excl", {reg_rd_en, reg_wr_en}, 2'b00);
                if (reg_wr_en) begin
                    if (wr_q.size() == 0) check_eq("unexp_wr", wr_q.size(), 1);
                    else begin
                        ew = wr_q.pop_front();
                        check_eq("wr_strobe", {reg_addr, reg_wdata}, ew);
                    end
                end
                if (reg_rd_en) begin
                    if (rd_q.size() == 0) check_eq("unexp_rd", rd_q.size(), 1);
                    else check_eq("rd_addr", reg_addr, rd_q.pop_front());
                end
                if (tx_valid && tx_ready) begin
                    if (byte_q.size() == 0) check_eq("unexp_tx", byte_q.size(), 1);
                    else begin
                        eb = byte_q.pop_front();
                        check_eq("tx_byte", tx_byte, eb[7:0]);
                        check_eq("tx_last", tx_last, eb[8]);
                        n_bytes++;
                    end
                end
            end
        end
    end

    task automatic start_req(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                             input logic ok);
        @(negedge clk_in);
        func_code = f; addr = a; data = d; rx_message_done = 1'b1;
        if (ok) expect_rsp(f, a, d);
        @(negedge clk_in);
        rx_message_done = 1'b0; crc_done = 1'b1; crc_ok = ok;
        @(negedge clk_in);
        crc_done = 1'b0; crc_ok = 1'b0;
        if (!ok) check_eq("crc_bad_busy", busy, 0);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 400) begin
            @(negedge clk_in);
            cyc++;
        end
        if (cyc >= 400) check_eq("timeout_busy", busy, 0);
        check_eq("bytes_left", byte_q.size(), 0);
        check_eq("wr_left", wr_q.size(), 0);
        check_eq("rd_left", rd_q.size(), 0);
    endtask

    task automatic wait_bytes(input int target);
        int cyc = 0;
        while (n_bytes < target && cyc < 400) begin
            @(negedge clk_in);
            cyc++;
        end
        if (cyc >= 400) check_eq("timeout_bytes", n_bytes, target);
    endtask

    task automatic do_req(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                          input logic ok);
        start_req(f, a, d, ok);
        wait_idle();
    endtask

    initial begin
        logic [7:0] saved;
        logic       saved_last;
        logic [7:0] f;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h5A00;
        mem[2] = 16'h1111; mem[3] = 16'h2222; mem[4] = 16'h3333;
        rst_n_in = 1'b0; rx_message_done = 1'b0; crc_done = 1'b0; crc_ok = 1'b0;
        func_code = 8'h00; addr = 16'h0000; data = 16'h0000;
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_strobes", {reg_rd_en, reg_wr_en}, 0);
        check_eq("rst_reg_out", {reg_addr, reg_wdata}, 0);
        check_eq("rst_tx_out", {tx_byte, tx_last}, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        do_req(8'h06, 16'h0003, 16'hBEEF, 1'b1);
        do_req(8'h03, 16'h0002, 16'h0003, 1'b1);
        do_req(8'h10, 16'h0000, 16'h0001, 1'b1);
        do_req(8'h03, 16'h000F, 16'h0002, 1'b1);
        do_req(8'h03, 16'h0000, 16'h0009, 1'b1);
        do_req(8'h03, 16'h0000, 16'h0000, 1'b1);
        do_req(8'h06, 16'h0010, 16'h1234, 1'b1);
        do_req(8'h03, 16'hFFFF, 16'h0002, 1'b1);
        do_req(8'h06, 16'h000F, 16'hA5A5, 1'b1);
        do_req(8'h06, 16'h0005, 16'h7777, 1'b0);

        // Simultaneous rx_message_done and crc_done: verdict is stale, must keep waiting.
        @(negedge clk_in);
        func_code = 8'h06; addr = 16'h0001; data = 16'h0001;
        rx_message_done = 1'b1; crc_done = 1'b1; crc_ok = 1'b1;
        @(negedge clk_in);
        rx_message_done = 1'b0; crc_done = 1'b0; crc_ok = 1'b0;
        repeat (3) @(negedge clk_in);
        check_eq("stale_crc_wait", busy, 1);
        crc_done = 1'b1;
        @(negedge clk_in);
        crc_done = 1'b0;
        check_eq("stale_crc_drop", busy, 0);

        // Back-pressure mid-response, with a stray request pulse that must be ignored.
        start_req(8'h03, 16'h0008, 16'h0008, 1'b1);
        wait_bytes(n_bytes + 4);
        stall = 1'b1;
        @(negedge clk_in);
        saved = tx_byte;
        saved_last = tx_last;
        func_code = 8'h06; addr = 16'h0000; data = 16'hDEAD; rx_message_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            rx_message_done = 1'b0;
            check_eq("stall_byte", tx_byte, saved);
            check_eq("stall_last", tx_last, saved_last);
            check_eq("stall_valid", tx_valid, 1);
        end
        stall = 1'b0;
        wait_idle();

        rand_rdy = 1'b1;
        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    f = 8'h03;
                2, 3:    f = 8'h06;
                default: f = 8'h10;
            endcase
            if (f == 8'h03) do_req(f, 16'($urandom_range(0, 18)), 16'($urandom_range(0, 9)), 1'b1);
            else            do_req(f, 16'($urandom_range(0, 18)), 16'($urandom), 1'b1);
        end
        rand_rdy = 1'b0;

        // Reset during TX abandons the frame; nothing may be re-emitted afterwards.
        start_req(8'h03, 16'h0000, 16'h0008, 1'b1);
        wait_bytes(n_bytes + 3);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_eq("rst_tx_valid_mid", tx_valid, 0);
        check_eq("rst_busy_mid", busy, 0);
        check_eq("rst_tx_byte_mid", {tx_byte, tx_last}, 0);
        byte_q.delete(); wr_q.delete(); rd_q.delete();
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check_eq("post_rst_idle", {tx_valid, busy}, 0);
        end
        do_req(8'h03, 16'h0002, 16'h0003, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/modbus_req_ctrl.md
MODBUS_REQ_CTRL -- requirements
Module: modbus_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR, default 8'h01: slave address echoed as byte 0 of every response.
REQ-002 SHALL have parameter REG_NUM, default 16: number of holding registers, legal addresses 0..REG_NUM-1, REG_NUM <= 256.
REQ-003 SHALL have parameter MAX_QTY, default 8: maximum register count accepted by function 0x03.
REQ-004 SHALL have ports:
  clk_in       in   1   system clock, the only clock
  rst_n_in     in   1   asynchronous active-low reset
  rx_message_done in 1  one-cycle pulse, request fields valid
  func_code    in   8   request function code
  addr         in   16  request register address
  data         in   16  write value (0x06) or quantity (0x03)
  crc_done     in   1   one-cycle pulse, CRC verdict valid
  crc_ok       in   1   CRC verdict, sampled with crc_done
  reg_rd_en    out  1   register read strobe
  reg_wr_en    out  1   register write strobe
  reg_addr     out  8   register index
  reg_wdata    out  16  write value
  reg_rdata    in   16  read value, valid the cycle after reg_rd_en
  tx_valid     out  1   response byte valid
  tx_ready     in   1   downstream accepts byte
  tx_byte      out  8   response byte, excluding CRC
  tx_last      out  1   marks final byte of response
  busy         out  1   high in every state except IDLE

Function
REQ-005 SHALL implement states IDLE, CRC_WAIT, CHECK, WRITE, READ, TX.
REQ-006 IDLE: on rx_message_done, latch func_code/addr/data, go to CRC_WAIT; a rx_message_done outside IDLE is ignored.
REQ-007 CRC_WAIT: on crc_done with crc_ok=1 go to CHECK; with crc_ok=0 return to IDLE, no response, no register access; crc_done and rx_message_done in the same IDLE cycle is ignored as a stale verdict.
REQ-008 CHECK (one cycle), priority order: func not 0x03/0x06 -> exception 0x01; func 0x03 with qty 0 or > MAX_QTY -> exception 0x03; addr+qty > REG_NUM (0x03) or addr >= REG_NUM (0x06), computed in 17 bits with no wrap -> exception 0x02; else go to READ (0x03) or WRITE (0x06).
REQ-009 WRITE: exactly one cycle with reg_wr_en=1, reg_addr=addr[7:0], reg_wdata=data, then TX.
REQ-010 READ: issue reg_rd_en for addr..addr+qty-1 on consecutive cycles, capture reg_rdata one cycle after each strobe into an internal MAX_QTY x 16 buffer, go to TX after the last capture; latency qty+1 cycles.
REQ-011 Response 0x06: ADDR, 0x06, addr hi, addr lo, data hi, data lo (6 bytes).
REQ-012 Response 0x03: ADDR, 0x03, 2*qty, then each register hi then lo in address order (3+2*qty bytes).
REQ-013 Exception response: ADDR, func_code|0x80, exception code (3 bytes).
REQ-014 TX: tx_valid high until the last byte is accepted; byte advances only when tx_valid and tx_ready are both high; tx_byte/tx_last stay stable while tx_ready=0; tx_last high only with the final byte; return to IDLE the cycle after the final handshake.
REQ-015 reg_rd_en and reg_wr_en are never high together and never high outside READ/WRITE.

Reset
REQ-016 Reset SHALL asynchronously force IDLE; clear all outputs, latched fields, buffer and counters to 0; a response in progress is abandoned, with no partial byte re-emitted after release.

Structure
REQ-017 Function codes 0x03/0x06, exception codes 0x01-0x03 and state encodings SHALL reside in a shared modbus package, reused by the frame transmitter.
REQ-018 A single sub-module, modbus_rsp_mux, SHALL select tx_byte from the byte index, response type and read buffer; all sequencing stays in the top.

Verification
REQ-019 Write 0x06 addr 0x0003 data 0xBEEF, crc_ok=1 -> one reg_wr_en at addr 3 with 0xBEEF; bytes 01 06 00 03 BE EF, tx_last on the 6th.
REQ-020 Read 0x03 addr 2 qty 3, regs 2..4 = 0x1111/0x2222/0x3333 -> bytes 01 03 06 11 11 22 22 33 33.
REQ-021 func 0x10 -> bytes 01 90 01; 0x03 addr 15 qty 2 -> 01 83 02; 0x03 qty 9 -> 01 83 03; in all three cases no register strobe occurs.
REQ-022 crc_ok=0 -> no tx_valid and no register strobe; busy low again the cycle after crc_done.
REQ-023 tx_ready held low for 5 cycles mid-response -> tx_byte stays stable and no byte is lost or duplicated; reset asserted during TX -> IDLE, tx_valid=0.
